// File: rtl/if_fetch_ctrl_if.sv
// Bundle between the IF fetch sequencer and the surrounding pipeline.
// The master side drives redirect/hazard/debug requests. The slave side (the sequencer) returns PC and IF/ID control.
interface if_fetch_ctrl_if #(
  parameter int PC_WIDTH = 8
);
  logic                PCSrc;
  logic [31:0]         EX_MEM_PC;
  logic                stall;
  logic                halt_req;
  logic                resume;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] PC_4_out;
  logic                fetch_valid;
  logic                if_id_write;
  logic                if_id_flush;
  logic [2:0]          state;
  logic [15:0]         fetch_count;
  logic                misalign_err;

  modport master (
    output PCSrc, EX_MEM_PC, stall, halt_req, resume,
    input  pc, PC_4_out, fetch_valid, if_id_write, if_id_flush,
           state, fetch_count, misalign_err
  );

  modport slave (
    input  PCSrc, EX_MEM_PC, stall, halt_req, resume,
    output pc, PC_4_out, fetch_valid, if_id_write, if_id_flush,
           state, fetch_count, misalign_err
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// MIPS IF-stage sequencer: owns the PC and arbitrates redirect, halt, stall and sequential fetch.
// It also drives the IF/ID load/flush enables, a saturating fetch counter and a sticky misalignment flag.
module if_fetch_ctrl #(
  parameter int                    PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  if_fetch_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              st, st_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt, pc_4, target;
  logic [2:0]          cnt_q, cnt_nxt;
  logic [15:0]         fcnt_q;
  logic                mis_q, mis_set, wr;
  logic                unused_tgt_bits;

  // Bits above PC_WIDTH are dropped on purpose; the reduction just consumes them.
  assign unused_tgt_bits = ^bus.EX_MEM_PC;
  assign target  = {bus.EX_MEM_PC[PC_WIDTH-1:2], 2'b00};
  assign pc_4    = pc_q + PC_WIDTH'(4);
  assign wr      = (st == RUN) & ~bus.stall & ~bus.halt_req & ~bus.PCSrc;
  assign mis_set = bus.PCSrc & (st != BOOT) & (|bus.EX_MEM_PC[1:0]);

  always_comb begin
    st_nxt  = st;
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    case (st)
      BOOT: st_nxt = RUN;
      RUN, STALL: begin
        if (bus.PCSrc) begin
          pc_nxt  = target;
          cnt_nxt = FLUSH_LOAD;
          st_nxt  = FLUSH;
        end else if (bus.halt_req) begin
          st_nxt = HALT;
        end else if (bus.stall) begin
          st_nxt = STALL;
        end else begin
          st_nxt = RUN;
          if (st == RUN) pc_nxt = pc_4;
        end
      end
      FLUSH: begin
        if (bus.PCSrc) begin
          pc_nxt  = target;
          cnt_nxt = FLUSH_LOAD;
        end else if (cnt_q != 3'd0) begin
          cnt_nxt = cnt_q - 3'd1;
        end else begin
          st_nxt = RUN;
        end
      end
      HALT: begin
        // A redirect arriving while halted is captured so it is not lost on resume.
        if (bus.PCSrc)       pc_nxt = target;
        else if (bus.resume) st_nxt = RUN;
      end
      default: st_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st     <= BOOT;
      pc_q   <= RESET_PC;
      cnt_q  <= 3'd0;
      fcnt_q <= 16'd0;
      mis_q  <= 1'b0;
    end else begin
      st    <= st_nxt;
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      if (wr && fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
      if (mis_set) mis_q <= 1'b1;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.PC_4_out     = pc_4;
  assign bus.state        = st;
  assign bus.fetch_valid  = (st == RUN) | (st == STALL);
  assign bus.if_id_write  = wr;
  assign bus.if_id_flush  = (st == FLUSH) | (bus.PCSrc & (st != BOOT));
  assign bus.fetch_count  = fcnt_q;
  assign bus.misalign_err = mis_q;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Sequencer for the MIPS instruction-fetch stage. It owns the program counter and presents the fetch address and PC+4 to the IF datapath. It also decides each cycle whether the IF/ID pipeline register loads, holds or is flushed. It arbitrates between sequential fetch, branch/jump redirect from EX/MEM, hazard stalls and debug halt/resume, and keeps a fetch counter plus a sticky misalignment flag.

## Interface
Parameters:
- PC_WIDTH, 8: width of the PC and the instruction-memory byte address.
- RESET_PC, 0: PC value loaded on reset.
- FLUSH_CYCLES, 1: bubble cycles after a redirect. Legal range is 1..7.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PCSrc  in  1  redirect request from EX/MEM, sampled each edge.
- EX_MEM_PC  in  32  redirect target. Only bits [PC_WIDTH-1:0] are used.
- stall  in  1  hazard-unit stall request.
- halt_req  in  1  debug halt request.
- resume  in  1  debug resume request.
- pc  out  PC_WIDTH  registered fetch address to instruction memory.
- PC_4_out  out  PC_WIDTH  combinational pc+4, modulo 2^PC_WIDTH.
- fetch_valid  out  1  instruction at pc is valid this cycle.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register clear. It has priority over if_id_write at the register.
- state  out  3  current state: BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4.
- fetch_count  out  16  count of instructions accepted into IF/ID. Saturates at 16'hFFFF.
- misalign_err  out  1  sticky flag: a redirect target had [1:0] != 0.

## Operation
- Reset (asynchronous, while reset_n=0): state=BOOT, pc=RESET_PC, fetch_count=0, misalign_err=0, flush counter=0.
- Reset mid-operation aborts every state immediately. No pending redirect survives reset.
- BOOT: lasts exactly one edge after reset_n rises, then goes to RUN. pc holds. All other inputs are ignored, including PCSrc.
- Priority at each edge in RUN and STALL: PCSrc > halt_req > stall > sequential.
- Redirect: pc <= {EX_MEM_PC[PC_WIDTH-1:2], 2'b00} and the flush counter loads FLUSH_CYCLES-1, then state goes to FLUSH. If EX_MEM_PC[1:0] != 0, misalign_err is set (sticky until reset).
- RUN:
  - halt_req=1 → HALT, pc holds.
  - stall=1 → STALL, pc holds.
  - Otherwise pc <= PC_4_out and fetch_count increments.
- STALL: pc holds. stall=0 → RUN. halt_req → HALT.
- FLUSH:
  - pc holds.
  - Counter nonzero: decrement it.
  - Counter zero: go to RUN.
  - PCSrc in FLUSH re-targets pc and reloads the counter.
  - stall and halt_req are ignored.
- HALT:
  - pc holds; resume=1 → RUN.
  - PCSrc in HALT updates pc (alignment rule applies) and stays in HALT, so a pending branch is not lost.
  - halt_req is ignored.
- Combinational outputs:
  - fetch_valid = state is RUN or STALL.
  - if_id_write = (state==RUN) & ~stall & ~halt_req & ~PCSrc.
  - if_id_flush = (state==FLUSH) | (PCSrc & state!=BOOT).
- Arithmetic:
  - PC_4_out = pc + 4, truncated to PC_WIDTH; 8'hFC wraps to 8'h00.
  - fetch_count increments only when if_id_write=1 and sticks at 16'hFFFF.
- Target bits above PC_WIDTH are discarded silently. That is not an error.

## Timing
- pc, state, fetch_count and misalign_err are registered. PC_4_out, fetch_valid, if_id_write and if_id_flush are combinational from state and inputs in the same cycle.
- Reset output values: pc=RESET_PC, PC_4_out=RESET_PC+4, fetch_valid=0, if_id_write=0, if_id_flush=0, state=0, fetch_count=0, misalign_err=0.
- First valid fetch is in the cycle after the first edge following reset release.
- Redirect latency:
  - Edge N samples PCSrc and pc becomes the target after edge N.
  - if_id_flush=1 during cycle N and during the FLUSH_CYCLES FLUSH cycles.
  - The target is fetched valid FLUSH_CYCLES+1 cycles after edge N.
- Stall: pc holds from the edge where stall=1 is sampled. Fetch resumes the cycle after stall drops.
- Simultaneous PCSrc and stall: the redirect wins and the stall is dropped for that edge.
- Simultaneous halt_req and stall: the state goes to HALT.

## Test plan
- Reset, then run free with RESET_PC=0 → pc sequence is 0 (BOOT), 0, 4, 8, …; fetch_count=3 after three RUN edges; PC_4_out tracks pc+4.
- Start at pc=8'hF8 and run → pc goes F8, FC, 00, 04; fetch_count never wraps when preloaded near 16'hFFFF, it sticks at FFFF.
- PCSrc=1 with EX_MEM_PC=32'h0000_0123 in RUN, FLUSH_CYCLES=2 → pc=8'h20; if_id_flush=1 for 3 cycles; state goes 3, 3, 1; misalign_err=1 and stays 1.
- Hold stall=1 for 3 cycles at pc=8'h10 → pc stays 10, if_id_write=0, state=2, fetch_valid=1. Raise PCSrc during the stall → redirect is taken and state goes to FLUSH.
- Raise halt_req in RUN, then pulse PCSrc to 8'h40, then resume → state stays 4 during HALT, pc=40 while halted, fetch at 40 after resume.
- Drop reset_n during FLUSH → all outputs return to reset values asynchronously; after release the sequence restarts from RESET_PC through BOOT.
